// File: rtl/move_cmd_gen.sv
// Button front end: synchronise, debounce, latch taps, auto-repeat held buttons and arbitrate
// into at most one movement command strobe per frame tick.
module move_cmd_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 371250,
  parameter int unsigned REPEAT_FRAMES   = 4
) (
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic [3:0] btn_in,
  input  logic       frame_tick_in,
  output logic       moveFwd,
  output logic       moveBack,
  output logic       rotLeft,
  output logic       rotRight,
  output logic       valid_out,
  output logic [3:0] held_out
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned FW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(REPEAT_FRAMES - 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    pend_q, pend_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [FW-1:0] frm_cnt_q, frm_cnt_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          valid_q, valid_d;
  logic [3:0]    cand_s, cancel_s, keep_s, win_s, rise_s;

  // Per-bit debounce: a level is accepted only after DEBOUNCE_CYCLES of continuous difference.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]    = '0;
        stable_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Frame-tick arbitration: cancel opposing pairs, then fwd > back > rotL > rotR.
  always_comb begin
    rise_s    = stable_d & ~stable_q;
    cand_s    = pend_q | (stable_q & {4{frm_cnt_q == FRM_LAST}});
    cancel_s  = {{2{cand_s[3] & cand_s[2]}}, {2{cand_s[1] & cand_s[0]}}};
    keep_s    = cand_s & ~cancel_s;
    win_s     = 4'b0000;
    pend_d    = pend_q | rise_s;
    frm_cnt_d = frm_cnt_q;
    cmd_d     = 4'b0000;
    valid_d   = 1'b0;
    if (keep_s[3]) begin
      win_s = 4'b1000;
    end else if (keep_s[2]) begin
      win_s = 4'b0100;
    end else if (keep_s[1]) begin
      win_s = 4'b0010;
    end else if (keep_s[0]) begin
      win_s = 4'b0001;
    end else begin
      win_s = 4'b0000;
    end
    if (frame_tick_in) begin
      // An edge accepted on the tick cycle itself must survive for the next tick.
      pend_d = (pend_q & ~cancel_s & ~win_s) | rise_s;
      if (|keep_s) begin
        valid_d   = 1'b1;
        cmd_d     = win_s;
        frm_cnt_d = '0;
      end else if (frm_cnt_q != FRM_LAST) begin
        frm_cnt_d = frm_cnt_q + FW'(1);
      end else begin
        frm_cnt_d = frm_cnt_q;
      end
    end else begin
      frm_cnt_d = frm_cnt_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      sync1_q   <= 4'b0000;
      sync2_q   <= 4'b0000;
      stable_q  <= 4'b0000;
      pend_q    <= 4'b0000;
      frm_cnt_q <= FRM_LAST;
      cmd_q     <= 4'b0000;
      valid_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      pend_q    <= pend_d;
      frm_cnt_q <= frm_cnt_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign moveFwd   = cmd_q[3];
  assign moveBack  = cmd_q[2];
  assign rotLeft   = cmd_q[1];
  assign rotRight  = cmd_q[0];
  assign valid_out = valid_q;
  assign held_out  = stable_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Scoreboard bench for move_cmd_gen: each frame tick pushes the expected command, the monitor
// pops it on the following cycle and requires silence on every other cycle.
module tb_move_cmd_gen;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] FWD  = 5'b11000;
  localparam logic [4:0] BACK = 5'b10100;
  localparam logic [4:0] ROTL = 5'b10010;
  localparam logic [4:0] ROTR = 5'b10001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic       tick = 1'b0;
  logic       mv_fwd, mv_back, rot_l, rot_r, valid;
  logic [3:0] held;
  logic [4:0] out_s;
  logic [4:0] exp_q [$];
  logic [4:0] e_s;
  logic       tick_seen = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  move_cmd_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_FRAMES(3)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .btn_in       (btn),
    .frame_tick_in(tick),
    .moveFwd      (mv_fwd),
    .moveBack     (mv_back),
    .rotLeft      (rot_l),
    .rotRight     (rot_r),
    .valid_out    (valid),
    .held_out     (held)
  );

  always #5 clk = ~clk;

  assign out_s = {valid, mv_fwd, mv_back, rot_l, rot_r};

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input logic [4:0] e);
    exp_q.push_back(e);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(3);
  endtask

  always @(posedge clk) tick_seen <= tick;

  // Strobe must appear exactly one cycle after a tick and never otherwise.
  always @(negedge clk) begin
    if (tick_seen) begin
      e_s = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h1F;
      check_eq("cmd", {11'd0, out_s}, {11'd0, e_s});
    end else begin
      check_eq("idle", {11'd0, out_s}, {11'd0, NONE});
    end
  end

  initial begin
    // Test 1: all buttons held through reset, both pairs cancel afterwards
    btn = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_out", {7'd0, out_s, held}, 16'h0000);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(10);
    check_eq("held_all", {12'd0, held}, 16'h000F);
    do_tick(NONE);
    do_tick(NONE);
    do_tick(NONE);
    btn = 4'h0;
    cyc(10);
    check_eq("held_rel", {12'd0, held}, 16'h0000);

    // Test 2: 3-cycle glitch must be rejected
    btn = 4'b1000;
    cyc(3);
    btn = 4'b0000;
    cyc(10);
    check_eq("glitch", {12'd0, held}, 16'h0000);
    do_tick(NONE);
    do_tick(NONE);

    // Test 3: held forward issues once, then every third tick
    btn = 4'b1000;
    cyc(10);
    check_eq("held_fwd", {12'd0, held}, 16'h0008);
    do_tick(FWD);
    do_tick(NONE);
    do_tick(NONE);
    do_tick(FWD);
    do_tick(NONE);
    do_tick(NONE);
    do_tick(FWD);
    btn = 4'b0000;
    cyc(10);
    do_tick(NONE);
    do_tick(NONE);
    do_tick(NONE);

    // Test 4: tap rotate-right between ticks
    btn = 4'b0001;
    cyc(10);
    btn = 4'b0000;
    cyc(10);
    check_eq("tap_rel", {12'd0, held}, 16'h0000);
    do_tick(ROTR);
    do_tick(NONE);

    // Test 5: fwd + rotL together, rotL waits in the tap latch
    btn = 4'b1010;
    cyc(10);
    check_eq("held_fl", {12'd0, held}, 16'h000A);
    btn = 4'b0000;
    cyc(10);
    do_tick(FWD);
    do_tick(ROTL);
    do_tick(NONE);

    // Test 6a: pending back is discarded by reset
    btn = 4'b0100;
    cyc(10);
    btn = 4'b0000;
    cyc(10);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    do_tick(NONE);

    // Test 6b: reset restores the repeat counter to its last value
    btn = 4'b1000;
    cyc(10);
    btn = 4'b0000;
    cyc(10);
    do_tick(FWD);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    btn = 4'b1100;
    cyc(10);
    do_tick(NONE);
    btn = 4'b1000;
    cyc(10);
    check_eq("held_f2", {12'd0, held}, 16'h0008);
    do_tick(FWD);
    btn = 4'b0000;
    cyc(10);
    do_tick(NONE);

    cyc(2);
    check_eq("sb_left", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
